// File: rtl/shift_add_mul_ctrl.sv
// Iterative shift-and-add multiplier sharing one N-bit ripple-carry adder.
// Define MUL_SIGNED_EN for two's-complement operands (adds a SIGN correction cycle).
module shift_add_mul_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = $clog2(N) + 1;

`ifdef MUL_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE, S_SIGN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     acc_hi_q, acc_hi_d;
  logic [N-1:0]     acc_lo_q, acc_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   product_q, product_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     add_x, add_y;
  logic             add_ci;
  logic [N:0]       add_r;
  logic             last_step;
`ifdef MUL_SIGNED_EN
  logic             neg_q, neg_d;
`endif

  // Ripple-carry adder returning {carry_out, sum}
  function automatic logic [N:0] rca(input logic [N-1:0] x, input logic [N-1:0] y,
                                     input logic ci);
    logic         c;
    logic [N-1:0] s;
    c = ci;
    for (int i = 0; i < int'(N); i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  assign last_step = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MUL_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
`ifdef MUL_SIGNED_EN
      S_CALC: if (last_step) state_d = S_SIGN;
      S_SIGN: state_d = S_DONE;
`else
      S_CALC: if (last_step) state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef MUL_SIGNED_EN
    neg_d     = neg_q;
`endif

    // Shared adder: partial-product add in CALC, low-half increment in SIGN
    add_x  = acc_hi_q;
    add_y  = acc_lo_q[0] ? mcand_q : '0;
    add_ci = 1'b0;
`ifdef MUL_SIGNED_EN
    if (state_q == S_SIGN) begin
      add_x  = ~acc_lo_q;
      add_y  = '0;
      add_ci = 1'b1;
    end
`endif
    add_r = rca(add_x, add_y, add_ci);

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef MUL_SIGNED_EN
          mcand_d = a[N-1] ? (~a + N'(1)) : a;
          acc_lo_d = b[N-1] ? (~b + N'(1)) : b;
          neg_d   = a[N-1] ^ b[N-1];
`else
          mcand_d  = a;
          acc_lo_d = b;
`endif
          acc_hi_d  = '0;
          cnt_d     = '0;
          product_d = '0;
          busy_d    = 1'b1;
        end
      end
      S_CALC: begin
        // Carry-out is kept: {c, sum, acc_lo} shifted right by one
        {acc_hi_d, acc_lo_d} = {add_r, acc_lo_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
`ifndef MUL_SIGNED_EN
        if (last_step) busy_d = 1'b0;
`endif
      end
`ifdef MUL_SIGNED_EN
      S_SIGN: begin
        if (neg_q) begin
          acc_lo_d = add_r[N-1:0];
          acc_hi_d = ~acc_hi_q + N'(add_r[N]);
        end
        busy_d = 1'b0;
      end
`endif
      S_DONE: begin
        product_d = {acc_hi_q, acc_lo_q};
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed-vector bench for shift_add_mul_ctrl, default unsigned N=8 build.
module tb_shift_add_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;

  int nvec = 0;
  int nerr = 0;

  shift_add_mul_ctrl #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One multiply: checks latency, busy length, single done pulse, no overlap, product
  task automatic run_mul(input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] exp,
                         input string tag);
    int lat = 0, busy_cnt = 0, done_cnt = 0, overlap = 0;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      a = 8'($urandom); b = 8'($urandom);
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = k;
      end
    end
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_busy"}, busy_cnt, 8);
    chk({tag, "_done1"}, done_cnt, 1);
    chk({tag, "_ovl"}, overlap, 0);
    chk({tag, "_prod"}, product, exp);
  endtask

  initial begin
    int d1, d2;
    logic [15:0] p1, p2;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", product, 0);
    @(negedge clk); rst_n = 1'b1;

    run_mul(8'd13,  8'd11,  16'h008F, "m13x11");
    run_mul(8'd255, 8'd255, 16'hFE01, "m255x255");
    run_mul(8'd0,   8'd200, 16'h0000, "m0x200");
    run_mul(8'd1,   8'd255, 16'h00FF, "m1x255");
    run_mul(8'd128, 8'd2,   16'h0100, "m128x2");
    run_mul(8'd200, 8'd0,   16'h0000, "m200x0");
    run_mul(8'd171, 8'd205, 16'h88EF, "m171x205");

    // Product hold over idle cycles with moving operands
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom);
      chk("hold_prod", product, 16'h88EF);
    end

    // start held high: first op unaffected, second accepted the cycle after done
    d1 = 0; d2 = 0; p1 = '0; p2 = '0;
    @(negedge clk);
    a = 8'd13; b = 8'd11; start = 1'b1;
    @(posedge clk); #1;
    a = 8'd255; b = 8'd255;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (k == 10) start = 1'b0;
      if (done && d1 == 0) begin d1 = k; p1 = product; end
      else if (done && d2 == 0) begin d2 = k; p2 = product; end
    end
    chk("b2b_d1", d1, 9);
    chk("b2b_p1", p1, 16'h008F);
    chk("b2b_d2", d2, 19);
    chk("b2b_p2", p2, 16'hFE01);

    // Async reset in CALC cycle 4 discards the operation
    d1 = 0;
    @(negedge clk);
    a = 8'd99; b = 8'd77; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_prod", product, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done || busy) d1++;
    end
    chk("mid_rst_quiet", d1, 0);
    run_mul(8'd99, 8'd77, 16'h1DC7, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
